// File: rtl/usb_tx_arbiter_pkg.sv
// Shared encodings for the USB transmit path: transmitter command codes,
// handshake PID selects and the arbiter FSM states.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      TXP_IDLE  = 3'd0,
      TXP_DATA0 = 3'd1,
      TXP_DATA1 = 3'd2,
      TXP_ACK   = 3'd3,
      TXP_NAK   = 3'd4,
      TXP_STALL = 3'd5
   } tx_packet_t;

   localparam logic [1:0] HS_PID_ACK   = 2'd0;
   localparam logic [1:0] HS_PID_NAK   = 2'd1;
   localparam logic [1:0] HS_PID_STALL = 2'd2;
   localparam logic [1:0] HS_PID_RSVD  = 2'd3;

   typedef enum logic [1:0] {
      ARB_IDLE       = 2'd0,
      ARB_WAIT_START = 2'd1,
      ARB_ACTIVE     = 2'd2,
      ARB_GAP        = 2'd3
   } arb_state_t;

   localparam logic OWN_HS   = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   // Reserved handshake select falls back to NAK.
   function automatic tx_packet_t pkt_code(input logic is_data, input logic [1:0] pid,
                                           input logic toggle);
      tx_packet_t c;
      if (is_data) begin
         c = toggle ? TXP_DATA1 : TXP_DATA0;
      end else begin
         case (pid)
            HS_PID_ACK:   c = TXP_ACK;
            HS_PID_STALL: c = TXP_STALL;
            default:      c = TXP_NAK;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/usb_tx_arb_timer.sv
// Saturating up-counter with clear, load and enable; term_o flags a match
// against the caller-selected terminal value.
module usb_tx_arb_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic [W-1:0] term_val_i,
   output logic         term_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/usb_tx_arbiter.sv
// Arbitrates the USB TX datapath between handshake and data-packet sources,
// supervises transmitter start/finish and enforces the inter-packet gap.
module usb_tx_arbiter
   import usb_tx_pkg::*;
#(
   parameter int IPG_CYCLES    = 16,
   parameter int START_TIMEOUT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_req,
   input  logic [1:0] hs_pid,
   output logic       hs_grant,
   output logic       hs_done,
   input  logic       data_req,
   input  logic       data_toggle,
   input  logic [6:0] data_len,
   input  logic [6:0] buffer_occupancy,
   output logic       data_grant,
   output logic       data_done,
   output logic       tx_err,
   output logic [2:0] tx_packet,
   input  logic       tx_transfer_active,
   input  logic       tx_error,
   output logic       busy
);

   localparam int CNT_MAX = (IPG_CYCLES > START_TIMEOUT) ? IPG_CYCLES : START_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] START_TERM = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0] IPG_TERM   = CW'(IPG_CYCLES - 1);

   arb_state_t state_q, state_d;
   tx_packet_t tx_packet_q, tx_packet_d;
   logic       owner_q, owner_d;
   logic [1:0] pid_q, pid_d;
   logic       toggle_q, toggle_d;
   logic       sticky_q, sticky_d;
   logic       hs_grant_q, hs_grant_d;
   logic       data_grant_q, data_grant_d;
   logic       hs_done_q, hs_done_d;
   logic       data_done_q, data_done_d;
   logic       tx_err_q, tx_err_d;

   logic          data_elig;
   logic          tmr_clr, tmr_en, tmr_hit;
   logic [CW-1:0] tmr_term;

   // Terminal value depends only on the current phase, keeping the
   // counter match free of any path through the next-state logic.
   assign tmr_term = (state_q == ARB_GAP) ? IPG_TERM : START_TERM;

   usb_tx_arb_timer #(.W(CW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (tmr_clr),
      .load_i     (1'b0),
      .load_val_i ({CW{1'b0}}),
      .en_i       (tmr_en),
      .term_val_i (tmr_term),
      .term_o     (tmr_hit)
   );

   assign data_elig = data_req && ((data_len == 7'd0) || (buffer_occupancy >= data_len));

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      pid_d        = pid_q;
      toggle_d     = toggle_q;
      sticky_d     = sticky_q;
      tx_packet_d  = TXP_IDLE;
      hs_grant_d   = 1'b0;
      data_grant_d = 1'b0;
      hs_done_d    = 1'b0;
      data_done_d  = 1'b0;
      tx_err_d     = 1'b0;
      tmr_clr      = 1'b0;
      tmr_en       = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            tmr_clr = 1'b1;
            if (hs_req) begin
               owner_d     = OWN_HS;
               pid_d       = hs_pid;
               toggle_d    = 1'b0;
               sticky_d    = 1'b0;
               hs_grant_d  = 1'b1;
               tx_packet_d = pkt_code(OWN_HS, hs_pid, 1'b0);
               state_d     = ARB_WAIT_START;
            end else if (data_elig) begin
               owner_d      = OWN_DATA;
               pid_d        = 2'd0;
               toggle_d     = data_toggle;
               sticky_d     = 1'b0;
               data_grant_d = 1'b1;
               tx_packet_d  = pkt_code(OWN_DATA, 2'd0, data_toggle);
               state_d      = ARB_WAIT_START;
            end
         end

         ARB_WAIT_START: begin
            tx_packet_d = pkt_code(owner_q, pid_q, toggle_q);
            if (tx_transfer_active) begin
               tx_packet_d = TXP_IDLE;
               sticky_d    = 1'b0;
               tmr_clr     = 1'b1;
               state_d     = ARB_ACTIVE;
            end else if (tmr_hit) begin
               tx_packet_d = TXP_IDLE;
               hs_done_d   = (owner_q == OWN_HS);
               data_done_d = (owner_q == OWN_DATA);
               tx_err_d    = 1'b1;
               tmr_clr     = 1'b1;
               state_d     = ARB_GAP;
            end else begin
               tmr_en = 1'b1;
            end
         end

         ARB_ACTIVE: begin
            sticky_d = sticky_q | tx_error;
            // An error on the final sampled cycle still counts.
            if (!tx_transfer_active) begin
               hs_done_d   = (owner_q == OWN_HS);
               data_done_d = (owner_q == OWN_DATA);
               tx_err_d    = sticky_q | tx_error;
               tmr_clr     = 1'b1;
               state_d     = ARB_GAP;
            end
         end

         ARB_GAP: begin
            if (tmr_hit) state_d = ARB_IDLE;
            else         tmr_en  = 1'b1;
         end

         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         tx_packet_q  <= TXP_IDLE;
         owner_q      <= OWN_HS;
         pid_q        <= 2'd0;
         toggle_q     <= 1'b0;
         sticky_q     <= 1'b0;
         hs_grant_q   <= 1'b0;
         data_grant_q <= 1'b0;
         hs_done_q    <= 1'b0;
         data_done_q  <= 1'b0;
         tx_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_packet_q  <= tx_packet_d;
         owner_q      <= owner_d;
         pid_q        <= pid_d;
         toggle_q     <= toggle_d;
         sticky_q     <= sticky_d;
         hs_grant_q   <= hs_grant_d;
         data_grant_q <= data_grant_d;
         hs_done_q    <= hs_done_d;
         data_done_q  <= data_done_d;
         tx_err_q     <= tx_err_d;
      end
   end

   assign hs_grant   = hs_grant_q;
   assign data_grant = data_grant_q;
   assign hs_done    = hs_done_q;
   assign data_done  = data_done_q;
   assign tx_err     = tx_err_q;
   assign tx_packet  = tx_packet_q;
   assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Scoreboard bench for usb_tx_arbiter: drivers push expected grants/dones,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_usb_tx_arbiter;

   localparam int IPG = 16;
   localparam int TMO = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hs_req = 1'b0;
   logic [1:0] hs_pid = 2'd0;
   logic       hs_grant, hs_done;
   logic       data_req = 1'b0;
   logic       data_toggle = 1'b0;
   logic [6:0] data_len = 7'd0;
   logic [6:0] buffer_occupancy = 7'd0;
   logic       data_grant, data_done, tx_err;
   logic [2:0] tx_packet;
   logic       tx_transfer_active = 1'b0;
   logic       tx_error = 1'b0;
   logic       busy;

   always #5 clk = ~clk;

   usb_tx_arbiter #(.IPG_CYCLES(IPG), .START_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .hs_req(hs_req), .hs_pid(hs_pid), .hs_grant(hs_grant), .hs_done(hs_done),
      .data_req(data_req), .data_toggle(data_toggle), .data_len(data_len),
      .buffer_occupancy(buffer_occupancy), .data_grant(data_grant), .data_done(data_done),
      .tx_err(tx_err), .tx_packet(tx_packet), .tx_transfer_active(tx_transfer_active),
      .tx_error(tx_error), .busy(busy)
   );

   typedef struct { bit owner; logic [2:0] code; } gexp_t;
   typedef struct { bit owner; bit err; bit tmo; } dexp_t;

   gexp_t gq[$];
   dexp_t dq[$];
   gexp_t g;
   dexp_t d;
   int checks = 0, errors = 0;
   int cyc = 0, grant_cyc = -1000, done_cyc = -1000;
   int gcount = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference encodings straight from the command table.
   function automatic logic [2:0] exp_hs(input int pid);
      case (pid)
         0: return 3'd3;
         2: return 3'd5;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [2:0] exp_data(input bit t);
      return t ? 3'd2 : 3'd1;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         chk("done_excl", {31'd0, hs_done & data_done}, 0);
         chk("grant_excl", {31'd0, hs_grant & data_grant}, 0);
         if (!(hs_done || data_done)) chk("err_without_done", {31'd0, tx_err}, 0);
         if (hs_grant || data_grant) begin
            gcount++;
            chk("grant_expected", gq.size() > 0, 1);
            if (gq.size() > 0) begin
               g = gq.pop_front();
               chk("grant_owner", {31'd0, data_grant}, {31'd0, g.owner});
               chk("grant_code", {29'd0, tx_packet}, {29'd0, g.code});
               chk("ipg_respected", (cyc - done_cyc) >= IPG + 1, 1);
            end
            grant_cyc = cyc;
         end
         if (hs_done || data_done) begin
            chk("done_expected", dq.size() > 0, 1);
            if (dq.size() > 0) begin
               d = dq.pop_front();
               chk("done_owner", {31'd0, data_done}, {31'd0, d.owner});
               chk("done_err", {31'd0, tx_err}, {31'd0, d.err});
               if (d.tmo) chk("timeout_latency", cyc - grant_cyc, TMO);
            end
            done_cyc = cyc;
         end
      end
   end

   task automatic wait_grant();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (hs_grant || data_grant) break;
      end
      chk("grant_seen", {31'd0, hs_grant | data_grant}, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (hs_done || data_done) break;
      end
      chk("done_seen", {31'd0, hs_done | data_done}, 1);
      chk("pkt_idle_after_done", {29'd0, tx_packet}, 0);
   endtask

   // Transmitter model; d < 0 means it never starts. Called on the grant negedge.
   task automatic xmit(input logic [2:0] code, input int dly, input int len, input int epos);
      @(negedge clk);
      chk("code_hold", {29'd0, tx_packet}, {29'd0, code});
      if (dly >= 0) begin
         repeat (dly) @(posedge clk);
         @(posedge clk); #1 tx_transfer_active = 1'b1;
         for (int i = 0; i < len; i++) begin
            tx_error = (i == epos);
            @(posedge clk); #1;
            if (i == 0) chk("pkt_zero_active", {29'd0, tx_packet}, 0);
         end
         tx_error = 1'b0;
         tx_transfer_active = 1'b0;
      end
      wait_done();
   endtask

   function automatic bit exp_err(input int dly, input int len, input int epos);
      return (dly < 0) || (epos >= 1 && epos < len);
   endfunction

   task automatic do_hs(input int pid, input int dly, input int len, input int epos);
      gq.push_back('{owner: 1'b0, code: exp_hs(pid)});
      dq.push_back('{owner: 1'b0, err: exp_err(dly, len, epos), tmo: dly < 0});
      hs_pid = 2'(pid);
      hs_req = 1'b1;
      wait_grant();
      hs_req = 1'b0;
      hs_pid = 2'($urandom);
      xmit(exp_hs(pid), dly, len, epos);
   endtask

   task automatic do_data(input bit tg, input int len, input int occ, input int dly,
                          input int plen, input int epos);
      gq.push_back('{owner: 1'b1, code: exp_data(tg)});
      dq.push_back('{owner: 1'b1, err: exp_err(dly, plen, epos), tmo: dly < 0});
      data_toggle = tg;
      data_len = 7'(len);
      buffer_occupancy = 7'(occ);
      data_req = 1'b1;
      wait_grant();
      data_req = 1'b0;
      data_toggle = ~tg;
      buffer_occupancy = 7'd0;
      xmit(exp_data(tg), dly, plen, epos);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, g0, kind, dly, plen, epos, len, occ;
      repeat (3) @(negedge clk);
      chk("rst_tx_packet", {29'd0, tx_packet}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_grants", {30'd0, hs_grant, data_grant}, 0);
      chk("rst_dones", {29'd0, hs_done, data_done, tx_err}, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // ACK, 20-cycle packet
      do_hs(0, 1, 20, -1);

      // collision: handshake wins, data follows after exactly the gap
      gq.push_back('{owner: 1'b0, code: 3'd3});
      gq.push_back('{owner: 1'b1, code: 3'd2});
      dq.push_back('{owner: 1'b0, err: 1'b0, tmo: 1'b0});
      dq.push_back('{owner: 1'b1, err: 1'b0, tmo: 1'b0});
      repeat (20) @(negedge clk);
      hs_pid = 2'd0; hs_req = 1'b1;
      data_len = 7'd0; buffer_occupancy = 7'd0; data_toggle = 1'b1; data_req = 1'b1;
      wait_grant();
      hs_req = 1'b0;
      xmit(3'd3, 1, 6, -1);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         n++;
         if (data_grant) break;
      end
      chk("collision_gap", n, IPG + 1);
      data_req = 1'b0;
      xmit(3'd2, 0, 5, -1);

      // occupancy gating, then release at the boundary occupancy == len
      repeat (20) @(negedge clk);
      g0 = gcount;
      data_toggle = 1'b0; data_len = 7'd10; buffer_occupancy = 7'd5; data_req = 1'b1;
      repeat (50) @(negedge clk);
      chk("gated_no_grant", gcount - g0, 0);
      gq.push_back('{owner: 1'b1, code: 3'd1});
      dq.push_back('{owner: 1'b1, err: 1'b0, tmo: 1'b0});
      buffer_occupancy = 7'd10;
      @(negedge clk);
      chk("occ_release_grant", {31'd0, data_grant}, 1);
      data_req = 1'b0;
      xmit(3'd1, 2, 4, -1);

      // start timeout and mid-packet error
      do_data(1'b0, 5, 9, -1, 2, -1);
      do_data(1'b1, 0, 0, 2, 8, 4);

      // reset mid-ACTIVE: no done, pending handshake granted afterwards
      repeat (20) @(negedge clk);
      gq.push_back('{owner: 1'b0, code: 3'd5});
      hs_pid = 2'd2; hs_req = 1'b1;
      wait_grant();
      hs_req = 1'b0;
      @(posedge clk); #1 tx_transfer_active = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      gq.push_back('{owner: 1'b0, code: 3'd4});
      dq.push_back('{owner: 1'b0, err: 1'b0, tmo: 1'b0});
      rst = 1'b1; hs_pid = 2'd3; hs_req = 1'b1; tx_transfer_active = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 0);
      chk("post_rst_pkt", {29'd0, tx_packet}, 0);
      rst = 1'b0;
      wait_grant();
      hs_req = 1'b0;
      xmit(3'd4, 1, 3, -1);

      // randomized traffic
      for (int t = 0; t < 30; t++) begin
         kind = $urandom_range(0, 1);
         dly  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
         plen = $urandom_range(2, 12);
         epos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, plen - 1)) : -1;
         if (kind == 0) begin
            do_hs($urandom_range(0, 3), dly, plen, epos);
         end else begin
            len = $urandom_range(0, 127);
            occ = (len == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(len, 127));
            do_data(1'($urandom), len, occ, dly, plen, epos);
         end
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end

      repeat (30) @(negedge clk);
      chk("grant_queue_drained", gq.size(), 0);
      chk("done_queue_drained", dq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
Shares the USB transmit datapath between two requesters: the protocol handshake source (ACK/NAK/STALL) and the data-packet source (DATA0/DATA1). It drives the transmitter's tx_packet command, tracks tx_transfer_active and tx_error, enforces an inter-packet gap, and reports per-packet completion and error. It sits between the protocol/endpoint logic and the USB TX top level.

Parameters:
IPG_CYCLES, 16, idle clk cycles enforced after every packet (including errored ones) before the next grant.
START_TIMEOUT, 32, clk cycles to wait for tx_transfer_active after issuing a command before declaring failure.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
hs_req  in  1  handshake request, level; held until hs_grant
hs_pid  in  2  handshake select: 0 ACK, 1 NAK, 2 STALL, 3 reserved (treated as NAK)
hs_grant  out  1  one-cycle pulse: handshake accepted, hs_pid latched
hs_done  out  1  one-cycle pulse: handshake packet finished
data_req  in  1  data-packet request, level; held until data_grant
data_toggle  in  1  0 = DATA0, 1 = DATA1; latched at grant
data_len  in  7  payload bytes; latched at grant; 0 = zero-length packet
buffer_occupancy  in  7  TX FIFO byte count
data_grant  out  1  one-cycle pulse: data request accepted
data_done  out  1  one-cycle pulse: data packet finished
tx_err  out  1  valid only with hs_done/data_done: 1 = timeout or transmitter error
tx_packet  out  3  command to transmitter (package encoding)
tx_transfer_active  in  1  transmitter busy
tx_error  in  1  transmitter error pulse/level
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, takes priority over all else): state IDLE, tx_packet = IDLE code (0), all grant/done/tx_err = 0, counter = 0, sticky error = 0, latched owner/pid/toggle cleared. A reset mid-packet produces no done pulse.
- FSM states: IDLE, WAIT_START, ACTIVE, GAP. Outputs are registered.
- IDLE: a handshake is eligible if hs_req = 1. Data is eligible if data_req = 1 and (data_len == 0 or buffer_occupancy >= data_len), unsigned 7-bit compare. Handshake has strict priority when both are eligible. On acceptance at edge N: latch owner, code and toggle; go to WAIT_START; the grant pulse is high during cycle N+1; tx_packet carries the code from cycle N+1.
- WAIT_START: hold tx_packet = code. If tx_transfer_active = 1, go to ACTIVE, set tx_packet = 0, clear the counter and sticky error. Otherwise increment the counter. When the counter reaches START_TIMEOUT-1 with no activity: pulse the owner's done with tx_err = 1, set tx_packet = 0, go to GAP.
- ACTIVE: tx_packet = 0. Sticky error |= tx_error. When tx_transfer_active is sampled 0: pulse the owner's done with tx_err = sticky | tx_error that cycle, then go to GAP.
- GAP: count IPG_CYCLES cycles, then go to IDLE. Requests arriving during GAP wait; they are never lost while held.
- A request deasserted after grant has no effect; the packet completes normally. New requests are not accepted in any state except IDLE.
- tx_err = 0 whenever no done pulse is present. hs_done and data_done are never high together.
- Counter width is $clog2(max(IPG_CYCLES, START_TIMEOUT)+1). The counter saturates and never wraps.
- Code mapping: handshake hs_pid 0/1/2/3 maps to ACK/NAK/STALL/NAK. Data maps to DATA0 or DATA1 by the latched toggle.

Decomposition:
- Package usb_tx_pkg:
  - tx_packet_t enum: IDLE=0, DATA0=1, DATA1=2, ACK=3, NAK=4, STALL=5.
  - hs_pid encoding constants.
  - Arbiter state enum.
  - The same encoding is used by txcu.
- One sub-module, usb_tx_arb_timer: a loadable, saturating up-counter with clear, enable and terminal-match outputs, shared by the START_TIMEOUT and IPG_CYCLES phases.

Test Plan:
- ACK: hs_req=1, hs_pid=0 in IDLE -> hs_grant pulses the next cycle; tx_packet=3 until active rises; active held 20 cycles then falls -> hs_done=1, tx_err=0; next grant no earlier than 16 cycles later.
- Collision: hs_req and data_req (len 0, toggle 1) asserted in the same cycle -> hs granted first (tx_packet=3); after done + 16 gap cycles, data granted with tx_packet=2.
- Occupancy gating: data_len=10, occupancy=5 -> no grant for 50 cycles. Raise occupancy to 10 -> data_grant the next cycle and tx_packet=1 (toggle=0).
- Timeout: grant data, keep tx_transfer_active=0 -> data_done and tx_err=1 exactly 32 cycles after tx_packet is first driven; tx_packet returns to 0.
- Error: during ACTIVE, pulse tx_error for 1 cycle mid-packet -> data_done with tx_err=1 at end of packet.
- Reset mid-ACTIVE: assert rst for 1 cycle -> the next cycle has busy=0 and tx_packet=0, and no done pulse; a pending hs_req is then granted normally.
